// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_unit
//  Purpose  : Instruction fetch stage. Owns the fetch PC, reads FETCH_WIDTH
//             consecutive instructions per cycle from a flat ROM, buffers the
//             groups in a FIFO and hands them to decode over valid/ready.
//             Supports redirect-with-flush and end-of-program signalling.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue_unit #(
  parameter int unsigned ROM_BYTES   = 1024,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROM_BYTES*8-1:0]   instr_rom,
  input  logic [31:0]              rom_size,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [FETCH_WIDTH*32-1:0] out_instr,
  output logic [FETCH_WIDTH-1:0]   out_mask,
  output logic                     fetch_complete
);

  localparam int unsigned ROM_WORDS    = ROM_BYTES / 4;
  localparam int unsigned WIDX         = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int unsigned PW           = $clog2(QUEUE_DEPTH);
  localparam int unsigned GW           = FETCH_WIDTH * 32;
  localparam logic [31:0] ROM_SIZE_MAX = 32'(ROM_BYTES);
  localparam logic [PW:0] CNT_FULL     = (PW+1)'(QUEUE_DEPTH);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d, w_remain;

  logic [31:0]     mem_pc_q    [QUEUE_DEPTH];
  logic [GW-1:0]   mem_instr_q [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0] mem_mask_q [QUEUE_DEPTH];

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_pc_q, out_pc_d;
  logic [GW-1:0]   out_instr_q, out_instr_d;
  logic [FETCH_WIDTH-1:0] out_mask_q, out_mask_d;
  logic            fc_q, fc_d;

  logic [31:0]     rom_words [ROM_WORDS];
  logic [31:0]     w_eff;
  logic [FETCH_WIDTH-1:0] w_lane_ok;
  logic [GW-1:0]   w_grp_instr;
  logic [31:0]     w_adv;
  logic            w_pop, w_can_push, w_push, w_bypass;

  // Word view of the flat ROM (instructions are word aligned).
  for (genvar w = 0; w < ROM_WORDS; w++) begin : g_rom_words
    assign rom_words[w] = instr_rom[32*w +: 32];
  end

  assign w_eff = (rom_size > ROM_SIZE_MAX) ? ROM_SIZE_MAX : rom_size;

  // Per-lane bound check uses a 33-bit end address so it can never wrap.
  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
    logic [32:0]     w_end;
    logic [WIDX-1:0] w_idx;
    assign w_end        = {1'b0, fetch_pc_q} + 33'(4*k + 4);
    assign w_idx        = fetch_pc_q[WIDX+1:2] + WIDX'(k);
    assign w_lane_ok[k] = (w_end <= {1'b0, w_eff});
    assign w_grp_instr[32*k +: 32] = w_lane_ok[k] ? rom_words[w_idx] : 32'h0;
  end

  // Fetch PC advance: four bytes per valid lane.
  always_comb begin
    w_adv = 32'h0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (w_lane_ok[k]) w_adv = w_adv + 32'd4;
    end
  end

  assign w_pop      = out_valid_q && out_ready;
  assign w_can_push = (count_q < CNT_FULL) || w_pop;
  assign w_push     = (state_q == S_RUN) && w_can_push && w_lane_ok[0] && !redirect_valid;
  assign w_remain   = count_q - {{PW{1'b0}}, w_pop};
  // A group pushed into an otherwise empty queue must reach the head directly.
  assign w_bypass   = w_push && (w_remain == '0);

  // Next-state logic: redirect overrides push and pop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      state_d    = S_RUN;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if ((state_q == S_RUN) && w_can_push && !w_lane_ok[0]) state_d = S_DONE;
      if (w_push) begin
        fetch_pc_d = fetch_pc_q + w_adv;
        tail_d     = tail_q + PW'(1);
      end
      if (w_pop) head_d = head_q + PW'(1);
      count_d = w_remain + {{PW{1'b0}}, w_push};
    end
  end

  // Registered head view, taken from the post-update queue contents.
  always_comb begin
    out_valid_d = (count_d != '0);
    out_pc_d    = '0;
    out_instr_d = '0;
    out_mask_d  = '0;
    fc_d        = (state_d == S_DONE) && (count_d == '0);
    if (count_d != '0) begin
      if (w_bypass) begin
        out_pc_d    = fetch_pc_q;
        out_instr_d = w_grp_instr;
        out_mask_d  = w_lane_ok;
      end else begin
        out_pc_d    = mem_pc_q[head_d];
        out_instr_d = mem_instr_q[head_d];
        out_mask_d  = mem_mask_q[head_d];
      end
    end
  end

  // Control state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      fetch_pc_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_mask_q  <= '0;
      fc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_mask_q  <= out_mask_d;
      fc_q        <= fc_d;
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_pc_q[tail_q]    <= fetch_pc_q;
      mem_instr_q[tail_q] <= w_grp_instr;
      mem_mask_q[tail_q]  <= w_lane_ok;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_instr      = out_instr_q;
  assign out_mask       = out_mask_q;
  assign fetch_complete = fc_q;

endmodule
`default_nettype wire
